// File: rtl/unstriping_pkg.sv
// unstriping_pkg
//   Definitions shared by the striping and unstriping blocks: default lane word
//   width, lane count, FIFO depth and the lane selector state encoding.
package unstriping_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int NUM_LANES  = 2;

  // Lane selector: which lane supplies the next word of the merged stream.
  typedef enum logic {
    SEL_0 = 1'b0,
    SEL_1 = 1'b1
  } sel_t;

endpackage

// File: rtl/unstriping_if.sv
// unstriping_if
//   Lane-side inputs and merged-stream outputs of the unstriping block.
//   Ports:
//     lane_0 / valid_0   lane 0 word and qualifier (even stream positions)
//     lane_1 / valid_1   lane 1 word and qualifier (odd stream positions)
//     data_out           merged word (registered in the block)
//     valid_out          data_out qualifier
//   Modports: master = the lane deserialisers and sink, slave = unstriping.
interface unstriping_if #(
  parameter int DW = 32
);
  logic [DW-1:0] lane_0;
  logic          valid_0;
  logic [DW-1:0] lane_1;
  logic          valid_1;
  logic [DW-1:0] data_out;
  logic          valid_out;

  modport master (
    output lane_0, valid_0, lane_1, valid_1,
    input  data_out, valid_out
  );

  modport slave (
    input  lane_0, valid_0, lane_1, valid_1,
    output data_out, valid_out
  );
endinterface

// File: rtl/unstriping_lane_fifo.sv
// unstriping_lane_fifo
//   Synchronous per-lane FIFO that absorbs skew between the two lanes.
//   Ports:
//     clk_2f, reset   clock and synchronous active-high reset
//     i_push, i_din   write request and word
//     i_pop           read request (ignored while empty)
//     o_dout          head word (valid when !o_empty)
//     o_empty, o_full occupancy flags
//     o_drop          push rejected this cycle (full, no simultaneous pop)
module unstriping_lane_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk_2f,
  input  logic          reset,
  input  logic          i_push,
  input  logic [DW-1:0] i_din,
  input  logic          i_pop,
  output logic [DW-1:0] o_dout,
  output logic          o_empty,
  output logic          o_full,
  output logic          o_drop
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          w_do_pop;
  logic          w_do_push;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  // A full FIFO still accepts a push when a word leaves on the same edge.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_drop    = i_push && !w_do_push;
  assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; the pointers alone define what is buffered.
  always_ff @(posedge clk_2f) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end
endmodule

// File: rtl/unstriping.sv
// unstriping
//   Merges two lane word streams back into one stream, alternating lane 0 then
//   lane 1. A stalled lane stalls the merge; lanes are never skipped.
//   Ports:
//     clk_2f      single clock
//     reset       synchronous active-high reset
//     bus         unstriping_if.slave: lane_0/valid_0, lane_1/valid_1 in,
//                 data_out/valid_out out (registered)
//     ovf_0/ovf_1 sticky lane overflow flags   (UNSTRIPING_STATUS_EN only)
//     word_count  words emitted since reset    (UNSTRIPING_STATUS_EN only)
//   Build option: define UNSTRIPING_STATUS_EN to add the status ports.
module unstriping
  import unstriping_pkg::*;
#(
  parameter int DW    = DATA_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic         clk_2f,
  input  logic         reset,
  unstriping_if.slave  bus
`ifdef UNSTRIPING_STATUS_EN
  ,
  output logic         ovf_0,
  output logic         ovf_1,
  output logic [15:0]  word_count
`endif
);
  sel_t          r_sel;
  logic [DW-1:0] r_data;
  logic          r_valid;

  logic [DW-1:0] w_dout_0, w_dout_1;
  logic          w_empty_0, w_empty_1;
  logic          w_full_0, w_full_1;
  logic          w_drop_0, w_drop_1;
  logic          w_pop_0, w_pop_1;

  // Only the selected lane may be popped, and only when it holds a word.
  assign w_pop_0 = (r_sel == SEL_0) && !w_empty_0;
  assign w_pop_1 = (r_sel == SEL_1) && !w_empty_1;

  unstriping_lane_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo_0 (
    .clk_2f  (clk_2f),
    .reset   (reset),
    .i_push  (bus.valid_0),
    .i_din   (bus.lane_0),
    .i_pop   (w_pop_0),
    .o_dout  (w_dout_0),
    .o_empty (w_empty_0),
    .o_full  (w_full_0),
    .o_drop  (w_drop_0)
  );

  unstriping_lane_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo_1 (
    .clk_2f  (clk_2f),
    .reset   (reset),
    .i_push  (bus.valid_1),
    .i_din   (bus.lane_1),
    .i_pop   (w_pop_1),
    .o_dout  (w_dout_1),
    .o_empty (w_empty_1),
    .o_full  (w_full_1),
    .o_drop  (w_drop_1)
  );

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      r_sel   <= SEL_0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_sel)
        SEL_0: begin
          if (w_pop_0) begin
            r_data  <= w_dout_0;
            r_valid <= 1'b1;
            r_sel   <= SEL_1;
          end else begin
            r_data  <= '0;
            r_valid <= 1'b0;
          end
        end
        default: begin
          if (w_pop_1) begin
            r_data  <= w_dout_1;
            r_valid <= 1'b1;
            r_sel   <= SEL_0;
          end else begin
            r_data  <= '0;
            r_valid <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.data_out  = r_data;
  assign bus.valid_out = r_valid;

`ifdef UNSTRIPING_STATUS_EN
  logic        r_ovf_0, r_ovf_1;
  logic [15:0] r_word_count;

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      r_ovf_0      <= 1'b0;
      r_ovf_1      <= 1'b0;
      r_word_count <= '0;
    end else begin
      if (w_drop_0) r_ovf_0 <= 1'b1;
      if (w_drop_1) r_ovf_1 <= 1'b1;
      // Counts words as they are loaded into the output register.
      if (w_pop_0 || w_pop_1) r_word_count <= r_word_count + 16'd1;
    end
  end

  assign ovf_0      = r_ovf_0;
  assign ovf_1      = r_ovf_1;
  assign word_count = r_word_count;
`else
  // Overflow is silent in this build; flags exist only to be ignored.
  logic w_unused;
  assign w_unused = &{1'b0, w_drop_0, w_drop_1, w_full_0, w_full_1};
`endif
endmodule
